axi_default_slave: RTL

- AXI4 responder behind the interconnect's default-slave slot (slave index 7, "no address range matched").
- Accepts every read and write burst routed to it and completes the full protocol handshake, so the master never hangs.
- Every response carries DECERR; write data is discarded and read data is zero.
- Read and write channels run independent state machines, one outstanding transaction each.

---
 rtl/axi_pkg.sv | 15 +
 rtl/axi_beat_cnt.sv | 38 +++
 rtl/axi_default_slave.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the default-slave responder: response codes,
// default field widths and the channel state encodings.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ID_W   = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

endpackage

// File: rtl/axi_beat_cnt.sv
// Read-burst beat counter: loaded with the burst length at the AR handshake,
// stepped on every R handshake, and exposes a registered "last beat" flag.
// The flag drops on the handshake of the final beat, so the count never wraps.
module axi_beat_cnt #(
  parameter int LEN_W = axi_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_len,
  input  logic             step,
  output logic             last
);

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len;

  // Load clears the count; each step advances it and precomputes the last flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      len  <= '0;
      last <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      len  <= load_len;
      last <= (load_len == '0);
    end else if (step) begin
      if (last) begin
        last <= 1'b0;
      end else begin
        cnt  <= cnt + 1'b1;
        last <= ((cnt + 1'b1) == len);
      end
    end
  end

endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave: completes every read and write burst with DECERR.
// Read data is zero, write data is discarded. Read and write channels are
// independent, one outstanding transaction each, all outputs registered.
// Optional build macro AXI_DEFAULT_SLAVE_STATS_EN adds saturating 16-bit
// counters of accepted AR and AW handshakes (err_rd_cnt / err_wr_cnt).
module axi_default_slave #(
  parameter int ID_W   = axi_pkg::ID_W,
  parameter int DATA_W = axi_pkg::DATA_W,
  parameter int LEN_W  = axi_pkg::LEN_W
) (
  input  logic                clk,
  input  logic                rst,
`ifdef AXI_DEFAULT_SLAVE_STATS_EN
  output logic [15:0]         err_rd_cnt,
  output logic [15:0]         err_wr_cnt,
`endif
  input  logic [ID_W-1:0]     ARID,
  input  logic [31:0]         ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ID_W-1:0]     AWID,
  input  logic [31:0]         AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

  import axi_pkg::*;

  r_state_t r_state;
  w_state_t w_state;

  logic ar_hs;
  logic aw_hs;
  logic r_hs;

  // Address, size, burst type and write payload carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{ARADDR, ARSIZE, ARBURST, AWADDR, AWLEN, AWSIZE,
                           AWBURST, WDATA, WSTRB};

  assign ar_hs = (r_state == R_IDLE) && ARREADY && ARVALID;
  assign aw_hs = (w_state == W_IDLE) && AWREADY && AWVALID;
  assign r_hs  = RVALID && RREADY;

  assign RDATA = '0;

  axi_beat_cnt #(.LEN_W(LEN_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ar_hs),
    .load_len (ARLEN),
    .step     (r_hs),
    .last     (RLAST)
  );

  // Read channel: accept one AR, stream len+1 zero beats with DECERR, repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RRESP   <= RESP_OKAY;
      RID     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            RID     <= ARID;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RRESP   <= RESP_DECERR;
            r_state <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs && RLAST) begin
            RVALID  <= 1'b0;
            RRESP   <= RESP_OKAY;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel: AW first, then swallow W beats until WLAST, then one B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      BID     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            BID     <= AWID;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (WVALID && WLAST) begin
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= RESP_DECERR;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

`ifdef AXI_DEFAULT_SLAVE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count decode-error transactions per direction, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_rd_cnt <= '0;
      err_wr_cnt <= '0;
    end else begin
      if (ar_hs) err_rd_cnt <= sat_inc(err_rd_cnt);
      if (aw_hs) err_wr_cnt <= sat_inc(err_wr_cnt);
    end
  end
`endif

endmodule
